// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and bit-reversal helper for the sequential
// FFT controller. The default N/W/LOG2N here match the controller's defaults.
package fft_pkg;

    localparam int N     = 8;
    localparam int W     = 16;
    localparam int LOG2N = $clog2(N);

    // Controller phases: gather a frame, run the stages, stream the bins out.
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Reverse the LOG2N address bits (natural index -> bit-reversed index).
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_seq_ctrl_bitrev.sv
// Combinational bit-reversal of a B-bit address; used to scatter natural-order
// input samples into the working buffer in the order the in-place stages expect.
module fft_bitrev_addr #(
    parameter int B = fft_pkg::LOG2N
) (
    input  logic [B-1:0] addr,
    output logic [B-1:0] rev
);

    // Mirror the address bits: bit i of the result is bit B-1-i of the input.
    always_comb begin
        rev = '0;
        for (int i = 0; i < B; i++) begin
            rev[i] = addr[B-1-i];
        end
    end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequential FFT controller. Loads N samples in bit-reversed order, drives an
// external combinational butterfly-stage datapath for log2(N) cycles, then
// streams the N bins out in natural order.
//
// Build option: define FFT_SEQ_SCALE_EN to halve every stage result on capture
// (arithmetic shift right, floor), giving an overall gain of 1/N. Without it the
// stage results are stored verbatim. Cycle timing is the same either way.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is high only in LOAD; out_valid is high only in DRAIN and the
// offered bin stays stable until out_ready accepts it. rst beats any handshake.
module fft_seq_ctrl #(
    parameter int N = fft_pkg::N,
    parameter int W = fft_pkg::W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_re,
    input  logic [W-1:0]           in_im,
    output logic [$clog2(N)-1:0]   stg_idx,
    output logic [N*W-1:0]         stg_xr,
    output logic [N*W-1:0]         stg_xi,
    input  logic [N*W-1:0]         stg_yr,
    input  logic [N*W-1:0]         stg_yi,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_re,
    output logic [W-1:0]           out_im,
    output logic                   out_last,
    output logic                   busy,
    output fft_pkg::state_t        dbg_state
);

    import fft_pkg::*;

    localparam int              AW       = $clog2(N);
    localparam logic [AW-1:0]   LAST_IDX = AW'(N - 1);
    localparam logic [AW-1:0]   LAST_STG = AW'(AW - 1);

    state_t              state;
    logic [AW-1:0]       cnt;
    logic [AW-1:0]       load_addr;
    logic                in_fire;
    logic                out_fire;

    logic signed [W-1:0] mem_re [N];
    logic signed [W-1:0] mem_im [N];
    logic signed [W-1:0] cap_re [N];
    logic signed [W-1:0] cap_im [N];

    // Bit-reversed write address for the sample currently being loaded.
    fft_bitrev_addr #(
        .B (AW)
    ) u_bitrev (
        .addr (cnt),
        .rev  (load_addr)
    );

    assign in_fire   = (state == ST_LOAD)  && in_valid  && in_ready;
    assign out_fire  = (state == ST_DRAIN) && out_valid && out_ready;
    assign out_re    = mem_re[cnt];
    assign out_im    = mem_im[cnt];
    assign dbg_state = state;

    // Unpack the stage result and apply the optional per-stage halving.
    always_comb begin
        for (int k = 0; k < N; k++) begin
`ifdef FFT_SEQ_SCALE_EN
            cap_re[k] = $signed(stg_yr[k*W +: W]) >>> 1;
            cap_im[k] = $signed(stg_yi[k*W +: W]) >>> 1;
`else
            cap_re[k] = stg_yr[k*W +: W];
            cap_im[k] = stg_yi[k*W +: W];
`endif
        end
    end

    // Present the whole working buffer to the stage datapath in every state.
    always_comb begin
        stg_xr = '0;
        stg_xi = '0;
        for (int k = 0; k < N; k++) begin
            stg_xr[k*W +: W] = mem_re[k];
            stg_xi[k*W +: W] = mem_im[k];
        end
    end

    // Working buffer: scattered writes while loading, full-frame capture while running.
    always_ff @(posedge clk) begin
        if (!rst && in_fire) begin
            mem_re[load_addr] <= in_re;
            mem_im[load_addr] <= in_im;
        end else if (!rst && state == ST_RUN) begin
            for (int k = 0; k < N; k++) begin
                mem_re[k] <= cap_re[k];
                mem_im[k] <= cap_im[k];
            end
        end
    end

    // Controller FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            cnt       <= '0;
            stg_idx   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_fire) begin
                        if (cnt == LAST_IDX) begin
                            state    <= ST_RUN;
                            cnt      <= '0;
                            stg_idx  <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stg_idx == LAST_STG) begin
                        state     <= ST_DRAIN;
                        stg_idx   <= '0;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end else begin
                        stg_idx <= stg_idx + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        if (cnt == LAST_IDX) begin
                            state     <= ST_LOAD;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            out_last <= (cnt == LAST_IDX - 1'b1);
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Bench for fft_seq_ctrl: behavioural radix-2 DIT stage model on the stage
// port, direct-DFT reference for the expected bins, timing and handshake checks.
`timescale 1ns/1ps
module tb_fft_seq_ctrl;

    localparam int  N     = 8;
    localparam int  W     = 16;
    localparam int  LG    = 3;
    localparam int  TOL_R = 6;
    localparam real PI    = 3.14159265358979;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_re;
    logic [W-1:0]    in_im;
    logic [LG-1:0]   stg_idx;
    logic [N*W-1:0]  stg_xr, stg_xi, stg_yr, stg_yi;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_re, out_im;
    logic            out_last;
    logic            busy;
    fft_pkg::state_t dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int frame_re [N];
    int frame_im [N];
    int first_acc, last_acc, last_xfer;

    logic [W-1:0] exp_re_q[$], exp_im_q[$];
    logic [W-1:0] got_re_q[$], got_im_q[$];
    logic         got_last_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_seq_ctrl #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .stg_idx(stg_idx), .stg_xr(stg_xr), .stg_xi(stg_xi), .stg_yr(stg_yr), .stg_yi(stg_yi),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_last(out_last), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- stage datapath model ----------------
    function automatic int tw_cos(input int i);
        return $rtoi($floor(16384.0 * $cos(2.0 * PI * real'(i) / real'(N)) + 0.5));
    endfunction
    function automatic int tw_sin(input int i);
        return $rtoi($floor(16384.0 * $sin(2.0 * PI * real'(i) / real'(N)) + 0.5));
    endfunction

    // One in-place DIT stage: span 2^(s+1), twiddle exp(-j*2*pi*k/span) in Q14.
    always_comb begin
        int half, tw, ar, ai, br, bi, pr, pim;
        half = 0; tw = 0; ar = 0; ai = 0; br = 0; bi = 0; pr = 0; pim = 0;
        stg_yr = stg_xr;
        stg_yi = stg_xi;
        half = 1 << stg_idx;
        for (int j = 0; j < N; j++) begin
            if ((j & half) == 0) begin
                tw  = (j % half) * (N / (2 * half));
                ar  = int'($signed(stg_xr[j*W +: W]));
                ai  = int'($signed(stg_xi[j*W +: W]));
                br  = int'($signed(stg_xr[(j+half)*W +: W]));
                bi  = int'($signed(stg_xi[(j+half)*W +: W]));
                pr  = (br * tw_cos(tw) + bi * tw_sin(tw) + 8192) >>> 14;
                pim = (bi * tw_cos(tw) - br * tw_sin(tw) + 8192) >>> 14;
                stg_yr[j*W +: W]        = W'(ar + pr);
                stg_yi[j*W +: W]        = W'(ai + pim);
                stg_yr[(j+half)*W +: W] = W'(ar - pr);
                stg_yi[(j+half)*W +: W] = W'(ai - pim);
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic build_expected();
        real sr, si, a;
        exp_re_q.delete();
        exp_im_q.delete();
        for (int k = 0; k < N; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < N; n++) begin
                a  = 2.0 * PI * real'(n * k) / real'(N);
                sr = sr + real'(frame_re[n]) * $cos(a) + real'(frame_im[n]) * $sin(a);
                si = si + real'(frame_im[n]) * $cos(a) - real'(frame_re[n]) * $sin(a);
            end
`ifdef FFT_SEQ_SCALE_EN
            sr = sr / real'(N);
            si = si / real'(N);
`endif
            exp_re_q.push_back(W'($rtoi($floor(sr + 0.5))));
            exp_im_q.push_back(W'($rtoi($floor(si + 0.5))));
        end
    endtask

    task automatic random_frame();
        for (int i = 0; i < N; i++) begin
            frame_re[i] = int'($urandom_range(0, 2000)) - 1000;
            frame_im[i] = int'($urandom_range(0, 2000)) - 1000;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_frame(input int budget);
        int  i;
        int  spent;
        int  edge_n;
        bit  acc;
        i = 0; spent = 0; first_acc = -1;
        while (i < N && spent < budget) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_re    = W'(frame_re[i]);
            in_im    = W'(frame_im[i]);
            acc      = in_ready;
            edge_n   = cyc + 1;
            @(posedge clk);
            if (acc) begin
                if (i == 0) first_acc = edge_n;
                last_acc = edge_n;
                i++;
            end
            spent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (i < N) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout accepted=%0d required=%0d", i, N);
        end
    endtask

    task automatic collect_frame(input bit rand_ready, input int budget);
        int spent;
        spent = 0;
        got_re_q.delete(); got_im_q.delete(); got_last_q.delete();
        while (got_re_q.size() < N && spent < budget) begin
            @(negedge clk);
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (out_valid && out_ready) begin
                got_re_q.push_back(out_re);
                got_im_q.push_back(out_im);
                got_last_q.push_back(out_last);
                last_xfer = cyc + 1;
            end
            @(posedge clk);
            spent++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        if (got_re_q.size() < N) begin
            n_cmp++; n_fail++;
            $display("FAIL collect_timeout bins=%0d required=%0d", got_re_q.size(), N);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_re = W'(777); in_im = W'(333); out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (out_last !== 1'b0)  begin n_fail++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        n_cmp++; if (stg_idx !== '0)     begin n_fail++; $display("FAIL reset_stg_idx got=%0d want=0", stg_idx); end
        n_cmp++; if (dbg_state !== fft_pkg::ST_LOAD) begin n_fail++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, fft_pkg::ST_LOAD); end
    endtask

    task automatic test_dc();
        int dr, di;
        for (int i = 0; i < N; i++) begin frame_re[i] = 1000; frame_im[i] = 0; end
        build_expected();
        send_frame(50);
        collect_frame(1'b1, 200);
        for (int i = 0; i < got_re_q.size(); i++) begin
            dr = int'($signed(got_re_q[i])) - int'($signed(exp_re_q[i]));
            di = int'($signed(got_im_q[i])) - int'($signed(exp_im_q[i]));
            n_cmp++;
            if (dr != 0 || di != 0) begin
                n_fail++;
                $display("FAIL dc_bin%0d got re=%0d im=%0d want re=%0d im=%0d", i,
                         $signed(got_re_q[i]), $signed(got_im_q[i]), $signed(exp_re_q[i]), $signed(exp_im_q[i]));
            end
            n_cmp++;
            if (got_last_q[i] !== (i == N - 1)) begin n_fail++; $display("FAIL dc_last%0d got=%b want=%b", i, got_last_q[i], (i == N - 1)); end
        end
    endtask

    task automatic test_impulse();
        int dr, di;
        for (int i = 0; i < N; i++) begin frame_re[i] = 0; frame_im[i] = 0; end
        frame_re[0] = 1000;
        build_expected();
        send_frame(50);
        collect_frame(1'b0, 200);
        for (int i = 0; i < got_re_q.size(); i++) begin
            dr = int'($signed(got_re_q[i])) - int'($signed(exp_re_q[i]));
            di = int'($signed(got_im_q[i])) - int'($signed(exp_im_q[i]));
            n_cmp++;
            if (dr != 0 || di != 0) begin
                n_fail++;
                $display("FAIL impulse_bin%0d got re=%0d im=%0d want re=%0d im=%0d", i,
                         $signed(got_re_q[i]), $signed(got_im_q[i]), $signed(exp_re_q[i]), $signed(exp_im_q[i]));
            end
            n_cmp++;
            if (got_last_q[i] !== (i == N - 1)) begin n_fail++; $display("FAIL impulse_last%0d got=%b want=%b", i, got_last_q[i], (i == N - 1)); end
        end
    endtask

    task automatic test_latency();
        int dr, di;
        random_frame();
        build_expected();
        send_frame(50);
        // Now just past the edge that accepted the last sample (cyc == last_acc).
        for (int d = 0; d <= LG; d++) begin
            if (d > 0) @(negedge clk);
            n_cmp++;
            if (out_valid !== (d == LG)) begin n_fail++; $display("FAIL latency_out_valid edge+%0d got=%b want=%b", d, out_valid, (d == LG)); end
            n_cmp++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL latency_in_ready edge+%0d got=%b want=0", d, in_ready); end
            n_cmp++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL latency_busy edge+%0d got=%b want=1", d, busy); end
        end
        collect_frame(1'b1, 200);
        for (int i = 0; i < got_re_q.size(); i++) begin
            dr = int'($signed(got_re_q[i])) - int'($signed(exp_re_q[i]));
            di = int'($signed(got_im_q[i])) - int'($signed(exp_im_q[i]));
            n_cmp++;
            if (dr > TOL_R || dr < -TOL_R || di > TOL_R || di < -TOL_R) begin
                n_fail++;
                $display("FAIL latency_bin%0d got re=%0d im=%0d want re=%0d im=%0d", i,
                         $signed(got_re_q[i]), $signed(got_im_q[i]), $signed(exp_re_q[i]), $signed(exp_im_q[i]));
            end
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL latency_in_ready_after got=%b want=1", in_ready); end
    endtask

    task automatic test_backpressure();
        int idx, stall, spent, dr, di;
        random_frame();
        build_expected();
        send_frame(50);
        idx = 0; stall = 0; spent = 0;
        while (idx < N && spent < 200) begin
            @(negedge clk);
            if (idx == 2 && stall < 5) begin
                out_ready = 1'b0;
                stall++;
                dr = int'($signed(out_re)) - int'($signed(exp_re_q[2]));
                di = int'($signed(out_im)) - int'($signed(exp_im_q[2]));
                n_cmp++;
                if (out_valid !== 1'b1 || dr > TOL_R || dr < -TOL_R || di > TOL_R || di < -TOL_R) begin
                    n_fail++;
                    $display("FAIL stall%0d got valid=%b re=%0d im=%0d want valid=1 re=%0d im=%0d", stall,
                             out_valid, $signed(out_re), $signed(out_im), $signed(exp_re_q[2]), $signed(exp_im_q[2]));
                end
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                dr = int'($signed(out_re)) - int'($signed(exp_re_q[idx]));
                di = int'($signed(out_im)) - int'($signed(exp_im_q[idx]));
                n_cmp++;
                if (dr > TOL_R || dr < -TOL_R || di > TOL_R || di < -TOL_R || out_last !== (idx == N - 1)) begin
                    n_fail++;
                    $display("FAIL bp_bin%0d got re=%0d im=%0d last=%b want re=%0d im=%0d last=%b", idx,
                             $signed(out_re), $signed(out_im), out_last, $signed(exp_re_q[idx]), $signed(exp_im_q[idx]), (idx == N - 1));
                end
                idx++;
            end
            @(posedge clk);
            spent++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (idx != N) begin n_fail++; $display("FAIL bp_count got=%0d want=%0d", idx, N); end
    endtask

    task automatic test_reset_mid_run();
        random_frame();
        send_frame(50);
        @(negedge clk);
        n_cmp++;
        if (stg_idx !== 3'd1 || dbg_state !== fft_pkg::ST_RUN) begin
            n_fail++; $display("FAIL midrun_pre got stg_idx=%0d state=%0d want stg_idx=1 state=%0d", stg_idx, dbg_state, fft_pkg::ST_RUN);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (dbg_state !== fft_pkg::ST_LOAD || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || stg_idx !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset got state=%0d ov=%b busy=%b ir=%b idx=%0d want state=0 ov=0 busy=0 ir=1 idx=0",
                     dbg_state, out_valid, busy, in_ready, stg_idx);
        end
        test_dc();
    endtask

    task automatic test_random();
        int dr, di;
        for (int f = 0; f < 4; f++) begin
            random_frame();
            build_expected();
            send_frame(50);
            collect_frame(1'b1, 300);
            for (int i = 0; i < got_re_q.size(); i++) begin
                dr = int'($signed(got_re_q[i])) - int'($signed(exp_re_q[i]));
                di = int'($signed(got_im_q[i])) - int'($signed(exp_im_q[i]));
                n_cmp++;
                if (dr > TOL_R || dr < -TOL_R || di > TOL_R || di < -TOL_R || got_last_q[i] !== (i == N - 1)) begin
                    n_fail++;
                    $display("FAIL rand%0d_bin%0d got re=%0d im=%0d last=%b want re=%0d im=%0d last=%b", f, i,
                             $signed(got_re_q[i]), $signed(got_im_q[i]), got_last_q[i],
                             $signed(exp_re_q[i]), $signed(exp_im_q[i]), (i == N - 1));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int dr, di;
        random_frame();
        build_expected();
        send_frame(50);
        random_frame();
        fork
            send_frame(300);
            collect_frame(1'b0, 200);
        join
        n_cmp++;
        if (first_acc != last_xfer + 1) begin
            n_fail++; $display("FAIL b2b_first_accept got edge=%0d want edge=%0d", first_acc, last_xfer + 1);
        end
        for (int i = 0; i < got_re_q.size(); i++) begin
            dr = int'($signed(got_re_q[i])) - int'($signed(exp_re_q[i]));
            di = int'($signed(got_im_q[i])) - int'($signed(exp_im_q[i]));
            n_cmp++;
            if (dr > TOL_R || dr < -TOL_R || di > TOL_R || di < -TOL_R) begin
                n_fail++; $display("FAIL b2b_a_bin%0d got re=%0d im=%0d want re=%0d im=%0d", i,
                                   $signed(got_re_q[i]), $signed(got_im_q[i]), $signed(exp_re_q[i]), $signed(exp_im_q[i]));
            end
        end
        build_expected();
        collect_frame(1'b1, 300);
        for (int i = 0; i < got_re_q.size(); i++) begin
            dr = int'($signed(got_re_q[i])) - int'($signed(exp_re_q[i]));
            di = int'($signed(got_im_q[i])) - int'($signed(exp_im_q[i]));
            n_cmp++;
            if (dr > TOL_R || dr < -TOL_R || di > TOL_R || di < -TOL_R) begin
                n_fail++; $display("FAIL b2b_b_bin%0d got re=%0d im=%0d want re=%0d im=%0d", i,
                                   $signed(got_re_q[i]), $signed(got_im_q[i]), $signed(exp_re_q[i]), $signed(exp_im_q[i]));
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;
        test_reset();
        test_dc();
        test_impulse();
        test_latency();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
